// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency instruction
// memory and presents one instruction per cycle to decode through the IF/ID register.
module fetch_unit #(
    parameter logic [15:0] PC_RESET  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirectPC,
    input  logic        haltDecoded,
    input  logic [15:0] imemData,
    input  logic        imemDone,
    output logic [15:0] imemAddr,
    output logic        imemRd,
    output logic [15:0] instrOut,
    output logic [15:0] pcPlus2Out,
    output logic        instrValid,
    output logic        halted,
    output logic        err
);

    typedef enum logic [1:0] {
        REQ    = 2'd0,
        HOLD   = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } fetchState_t;

    fetchState_t state, stateNext;

    logic [15:0] pc, pcNext;
    logic [15:0] instrNext, pcPlus2Next;
    logic        validNext;
    logic [15:0] bufInstr, bufInstrNext;
    logic [15:0] bufPcPlus2, bufPcPlus2Next;
    logic [15:0] drainAddr, drainAddrNext;
    logic        errNext;
    logic [15:0] pcPlus2;
    logic        haltNow;

    assign pcPlus2 = pc + 16'd2;
    assign haltNow = haltDecoded && instrValid && !stall && !redirect;

    // DRAIN keeps presenting the abandoned address so the memory sees a stable request.
    assign imemRd   = !rst && ((state == REQ) || (state == DRAIN));
    assign imemAddr = (state == DRAIN) ? drainAddr : pc;
    assign halted   = (state == HALTED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= REQ;
            pc         <= PC_RESET;
            instrOut   <= NOP_INSTR;
            pcPlus2Out <= 16'h0000;
            instrValid <= 1'b0;
            bufInstr   <= NOP_INSTR;
            bufPcPlus2 <= 16'h0000;
            drainAddr  <= 16'h0000;
            err        <= 1'b0;
        end else begin
            state      <= stateNext;
            pc         <= pcNext;
            instrOut   <= instrNext;
            pcPlus2Out <= pcPlus2Next;
            instrValid <= validNext;
            bufInstr   <= bufInstrNext;
            bufPcPlus2 <= bufPcPlus2Next;
            drainAddr  <= drainAddrNext;
            err        <= errNext;
        end
    end

    always_comb begin
        stateNext      = state;
        pcNext         = pc;
        instrNext      = instrOut;
        pcPlus2Next    = pcPlus2Out;
        validNext      = instrValid;
        bufInstrNext   = bufInstr;
        bufPcPlus2Next = bufPcPlus2;
        drainAddrNext  = drainAddr;
        errNext        = err;

        if (state != HALTED) begin
            if (redirect) begin
                pcNext         = {redirectPC[15:1], 1'b0};
                instrNext      = NOP_INSTR;
                validNext      = 1'b0;
                bufInstrNext   = NOP_INSTR;
                bufPcPlus2Next = 16'h0000;
                errNext        = err | redirectPC[0];
                // An outstanding request in REQ must still be drained before refetching.
                case (state)
                    REQ: begin
                        if (imemDone) begin
                            stateNext = REQ;
                        end else begin
                            stateNext     = DRAIN;
                            drainAddrNext = pc;
                        end
                    end
                    HOLD:    stateNext = REQ;
                    DRAIN:   stateNext = imemDone ? REQ : DRAIN;
                    default: stateNext = state;
                endcase
            end else if (haltNow) begin
                stateNext      = HALTED;
                instrNext      = NOP_INSTR;
                validNext      = 1'b0;
                bufInstrNext   = NOP_INSTR;
                bufPcPlus2Next = 16'h0000;
            end else begin
                case (state)
                    REQ: begin
                        if (imemDone && !stall) begin
                            instrNext   = imemData;
                            pcPlus2Next = pcPlus2;
                            validNext   = 1'b1;
                            pcNext      = pcPlus2;
                        end else if (imemDone && stall) begin
                            bufInstrNext   = imemData;
                            bufPcPlus2Next = pcPlus2;
                            stateNext      = HOLD;
                        end else if (!stall) begin
                            instrNext = NOP_INSTR;
                            validNext = 1'b0;
                        end
                    end
                    HOLD: begin
                        if (!stall) begin
                            instrNext   = bufInstr;
                            pcPlus2Next = bufPcPlus2;
                            validNext   = 1'b1;
                            pcNext      = pcPlus2;
                            stateNext   = REQ;
                        end
                    end
                    DRAIN: begin
                        if (imemDone) begin
                            stateNext = REQ;
                        end
                    end
                    default: stateNext = state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming fetch, slow memory, stall/hold, redirect
// with drain, halt persistence, asynchronous reset and PC wrap-around.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirectPC;
    logic        haltDecoded;
    logic [15:0] imemData;
    logic        imemDone;
    logic [15:0] imemAddr;
    logic        imemRd;
    logic [15:0] instrOut;
    logic [15:0] pcPlus2Out;
    logic        instrValid;
    logic        halted;
    logic        err;

    logic        overrideEn;
    logic [15:0] overrideData;

    logic        rst2;
    logic [15:0] imemData2;
    logic [15:0] imemAddr2;
    logic        imemRd2;
    logic [15:0] instrOut2;
    logic [15:0] pcPlus2Out2;
    logic        instrValid2;
    logic        halted2;
    logic        err2;

    int total = 0;
    int bad   = 0;

    // Memory model: every word is 0x4000 plus its address unless overridden.
    assign imemData  = overrideEn ? overrideData : (16'h4000 + imemAddr);
    assign imemData2 = 16'h4000 + imemAddr2;

    fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirectPC(redirectPC), .haltDecoded(haltDecoded),
        .imemData(imemData), .imemDone(imemDone), .imemAddr(imemAddr),
        .imemRd(imemRd), .instrOut(instrOut), .pcPlus2Out(pcPlus2Out),
        .instrValid(instrValid), .halted(halted), .err(err)
    );

    fetch_unit #(.PC_RESET(16'hFFFC)) dutWrap (
        .clk(clk), .rst(rst2), .stall(1'b0), .redirect(1'b0),
        .redirectPC(16'h0000), .haltDecoded(1'b0),
        .imemData(imemData2), .imemDone(1'b1), .imemAddr(imemAddr2),
        .imemRd(imemRd2), .instrOut(instrOut2), .pcPlus2Out(pcPlus2Out2),
        .instrValid(instrValid2), .halted(halted2), .err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic s, input logic r, input logic [15:0] rpc,
                                 input logic h, input logic d);
        stall       = s;
        redirect    = r;
        redirectPC  = rpc;
        haltDecoded = h;
        imemDone    = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        rst          = 1'b1;
        rst2         = 1'b1;
        overrideEn   = 1'b0;
        overrideData = 16'h0000;
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);

        // Reset state
        tick();
        tick();
        checkOutput("rstInstr", instrOut, 16'h0800);
        checkOutput("rstValid", {15'd0, instrValid}, 16'd0);
        checkOutput("rstPcPlus2", pcPlus2Out, 16'h0000);
        checkOutput("rstHalted", {15'd0, halted}, 16'd0);
        checkOutput("rstErr", {15'd0, err}, 16'd0);
        checkOutput("rstRd", {15'd0, imemRd}, 16'd0);
        rst = 1'b0;
        #1;
        checkOutput("firstRd", {15'd0, imemRd}, 16'd1);
        checkOutput("firstAddr", imemAddr, 16'h0000);

        // Streaming fetch, memory answers in the request cycle
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("streamInstr", instrOut, 16'h4000 + 16'(2 * k));
            checkOutput("streamPcPlus2", pcPlus2Out, 16'(2 * k + 2));
            checkOutput("streamValid", {15'd0, instrValid}, 16'd1);
            checkOutput("streamAddr", imemAddr, 16'(2 * k + 2));
        end

        // Three-cycle memory latency for addresses 0x0008 and 0x000A
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
            for (int w = 0; w < 2; w++) begin
                tick();
                checkOutput("slowAddr", imemAddr, 16'h0008 + 16'(2 * k));
                checkOutput("slowRd", {15'd0, imemRd}, 16'd1);
                checkOutput("slowBubble", instrOut, 16'h0800);
                checkOutput("slowValid", {15'd0, instrValid}, 16'd0);
                checkOutput("slowPcPlus2Hold", pcPlus2Out, 16'h0008 + 16'(2 * k));
            end
            applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
            tick();
            checkOutput("slowInstr", instrOut, 16'h4008 + 16'(2 * k));
            checkOutput("slowValidOk", {15'd0, instrValid}, 16'd1);
        end

        // Stall for four cycles while the word at 0x000C is returned
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("stallInstr", instrOut, 16'h400A);
            checkOutput("stallValid", {15'd0, instrValid}, 16'd1);
            checkOutput("stallRd", {15'd0, imemRd}, 16'd0);
        end
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        tick();
        checkOutput("unstallInstr", instrOut, 16'h400C);
        checkOutput("unstallPcPlus2", pcPlus2Out, 16'h000E);
        checkOutput("unstallAddr", imemAddr, 16'h000E);
        checkOutput("unstallRd", {15'd0, imemRd}, 16'd1);
        tick();
        checkOutput("afterStallInstr", instrOut, 16'h400E);

        // Redirect while the fetch of 0x0010 is outstanding
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
        tick();
        checkOutput("redirBubble", instrOut, 16'h0800);
        checkOutput("redirValid", {15'd0, instrValid}, 16'd0);
        checkOutput("drainAddr", imemAddr, 16'h0010);
        checkOutput("drainRd", {15'd0, imemRd}, 16'd1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        checkOutput("drainAddrHeld", imemAddr, 16'h0010);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        tick();
        checkOutput("drainDiscard", instrOut, 16'h0800);
        checkOutput("drainDiscardValid", {15'd0, instrValid}, 16'd0);
        checkOutput("targetAddr", imemAddr, 16'h0100);
        tick();
        checkOutput("targetInstr", instrOut, 16'h4100);
        checkOutput("targetPcPlus2", pcPlus2Out, 16'h0102);
        checkOutput("noErrYet", {15'd0, err}, 16'd0);

        // Misaligned redirect target
        applyStimulus(1'b0, 1'b1, 16'h0101, 1'b0, 1'b1);
        tick();
        checkOutput("misalignErr", {15'd0, err}, 16'd1);
        checkOutput("misalignAddr", imemAddr, 16'h0100);
        checkOutput("misalignBubble", instrOut, 16'h0800);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        tick();
        checkOutput("misalignInstr", instrOut, 16'h4100);
        checkOutput("errSticky", {15'd0, err}, 16'd1);

        // Halt on a decoded dump instruction
        overrideEn   = 1'b1;
        overrideData = 16'h0000;
        tick();
        checkOutput("haltInstr", instrOut, 16'h0000);
        checkOutput("haltInstrValid", {15'd0, instrValid}, 16'd1);
        overrideEn = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        tick();
        checkOutput("halted", {15'd0, halted}, 16'd1);
        checkOutput("haltRd", {15'd0, imemRd}, 16'd0);
        checkOutput("haltValid", {15'd0, instrValid}, 16'd0);
        checkOutput("haltBubble", instrOut, 16'h0800);
        checkOutput("haltAddr", imemAddr, 16'h0104);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b0, k[0], 16'h0200, 1'b0, 1'b1);
            tick();
        end
        checkOutput("haltPersist", {15'd0, halted}, 16'd1);
        checkOutput("haltPersistRd", {15'd0, imemRd}, 16'd0);
        checkOutput("haltPersistAddr", imemAddr, 16'h0104);
        checkOutput("haltPersistValid", {15'd0, instrValid}, 16'd0);

        // Asynchronous reset in the middle of a cycle
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncHalted", {15'd0, halted}, 16'd0);
        checkOutput("asyncRd", {15'd0, imemRd}, 16'd0);
        checkOutput("asyncInstr", instrOut, 16'h0800);
        checkOutput("asyncPcPlus2", pcPlus2Out, 16'h0000);
        checkOutput("asyncErr", {15'd0, err}, 16'd0);
        checkOutput("asyncAddr", imemAddr, 16'h0000);
        checkOutput("asyncValid", {15'd0, instrValid}, 16'd0);

        // PC wrap-around from a reset value of 0xFFFC
        tick();
        rst2 = 1'b0;
        #1;
        checkOutput("wrapFirstAddr", imemAddr2, 16'hFFFC);
        tick();
        checkOutput("wrapInstr0", instrOut2, 16'h3FFC);
        checkOutput("wrapPc0", pcPlus2Out2, 16'hFFFE);
        tick();
        checkOutput("wrapInstr1", instrOut2, 16'h3FFE);
        checkOutput("wrapPc1", pcPlus2Out2, 16'h0000);
        tick();
        checkOutput("wrapInstr2", instrOut2, 16'h4000);
        checkOutput("wrapPc2", pcPlus2Out2, 16'h0002);
        checkOutput("wrapErr", {15'd0, err2}, 16'd0);
        checkOutput("wrapValid", {15'd0, instrValid2}, 16'd1);
        checkOutput("wrapHalted", {15'd0, halted2}, 16'd0);
        checkOutput("wrapRd", {15'd0, imemRd2}, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the decode/control unit. It owns the PC register and issues requests to a variable-latency instruction memory. It holds the fetched word in an IF/ID register whose instrOut drives decode, and inserts NOP bubbles on stall drain, redirect and halt. It consumes decode's createDump (as haltDecoded) and the redirect target from execute.

Parameters:
PC_RESET, 16'h0000, PC value after reset.
NOP_INSTR, 16'h0800, bubble word (opcode 00001 = NOP).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous active-high reset.
stall  in  1  decode hazard hold; IF/ID must not advance.
redirect  in  1  taken branch/jump from downstream.
redirectPC  in  16  redirect target.
haltDecoded  in  1  decode's createDump for the current instrOut.
imemData  in  16  instruction memory read data.
imemDone  in  1  imemData valid this cycle.
imemAddr  out  16  fetch address.
imemRd  out  1  fetch request.
instrOut  out  16  IF/ID instruction to decode.
pcPlus2Out  out  16  IF/ID PC+2 of instrOut, used for JAL/JALR writeback and branch adder.
instrValid  out  1  instrOut is a real instruction.
halted  out  1  sticky; fetch stopped.
err  out  1  sticky; misaligned redirect seen.

Behaviour:
- Reset (async, any time, including mid-transaction):
  - PC=PC_RESET, state=REQ, instrOut=NOP_INSTR, pcPlus2Out=0, instrValid=0, halted=0, err=0, holding buffer empty.
  - imemRd=0 while rst is high.
- FSM states: REQ, HOLD, DRAIN, HALTED. imemAddr=PC in REQ/HOLD/HALTED. In DRAIN, imemAddr holds the address of the abandoned transaction.
- REQ:
  - imemRd=1, imemAddr=PC held stable until imemDone=1 is sampled. imemDone may arrive in the same cycle as the request, or any number of cycles later.
  - Edge with imemDone=1, stall=0: IF/ID <= {imemData, PC+2, valid=1}; PC <= PC+2; stay REQ (new request next cycle).
  - Edge with imemDone=1, stall=1: buffer <= {imemData, PC+2}; IF/ID unchanged; go HOLD.
  - Edge with imemDone=0, stall=0: IF/ID <= {NOP_INSTR, valid=0}, with pcPlus2Out unchanged.
  - Edge with imemDone=0, stall=1: IF/ID unchanged.
- HOLD:
  - imemRd=0.
  - Edge with stall=0: IF/ID <= buffer with valid=1; PC <= PC+2; go REQ.
- DRAIN (an abandoned fetch is still outstanding):
  - imemRd=1 with the old address.
  - On imemDone the data is discarded; go REQ at the current PC.
  - IF/ID held at the bubble.
- Redirect (priority over stall, halt and normal fetch; ignored in HALTED):
  - At the edge: PC <= {redirectPC[15:1],1'b0}; IF/ID <= bubble (NOP_INSTR, valid=0); buffer cleared.
  - Next state:
    - from REQ with imemDone=0 -> DRAIN;
    - from REQ with imemDone=1, or from HOLD -> REQ;
    - from DRAIN with imemDone=0 -> DRAIN (PC updated);
    - from DRAIN with imemDone=1 -> REQ.
  - redirectPC[0]=1 sets err (sticky until rst).
- Halt:
  - Edge with haltDecoded=1, instrValid=1, stall=0, redirect=0 -> HALTED.
  - IF/ID <= bubble; buffer dropped; halted=1.
  - Any outstanding response is ignored: HALTED asserts imemRd=0, and imemDone is don't-care thereafter.
  - HALTED is left only by rst.
- Arithmetic: PC and PC+2 are 16-bit modulo; 16'hFFFE+2 = 16'h0000, with no error.
- stall while instrValid=0 holds the bubble; no constraint on stall timing.

Test Plan:
1. Reset, imemDone tied high, imemData=16'h4000+addr, stall=0 -> imemAddr 0,2,4…; instrOut=4000,4002… one per cycle with pcPlus2Out=addr+2; first valid instruction appears on the 1st edge after reset release.
2. imemDone 3 cycles after each request -> imemRd/imemAddr stable for 3 cycles; instrOut=NOP_INSTR with instrValid=0 during the gaps; no PC skip.
3. stall=1 for 4 cycles while fetching addr 6 -> instrOut holds addr-4 word, imemRd=0 in HOLD; after stall drops, the addr-6 word appears, then addr 8 is requested; no duplicate or lost word.
4. Redirect to 16'h0100 while a 3-cycle fetch is outstanding -> IF/ID bubble next edge, DRAIN keeps the old address until imemDone, that response is never presented, next request is at 0x0100. Redirect to 16'h0101 -> err=1 and fetch from 0x0100.
5. instrOut=16'h0000 with haltDecoded=1 -> next edge halted=1, imemRd=0, instrValid=0, and the state persists through 20 cycles of redirect pulses; then assert rst mid-cycle -> all outputs at reset values immediately.
6. PC_RESET=16'hFFFC -> fetches FFFC, FFFE, 0000 with pcPlus2Out=FFFE, 0000, 0002.
